// File: rtl/core_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one shared memory port with anti-starvation.
// Define ARB_TIMEOUT_EN to build in the bus watchdog that aborts stalled transfers.
module core_mem_arbiter #(
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic [31:0] IF_RDATA,
    output logic        IF_DONE,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    input  logic [3:0]  D_STRB,
    output logic [31:0] D_RDATA,
    output logic        D_DONE,
    output logic        BUS_VALID,
    output logic        BUS_WE,
    output logic [31:0] BUS_ADDR,
    output logic [31:0] BUS_WDATA,
    output logic [3:0]  BUS_STRB,
    input  logic        BUS_READY,
    input  logic [31:0] BUS_RDATA,
    output logic        MEM_BUSY,
    output logic        BUS_ERR
);

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam int          SW       = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, IF_XFER, D_XFER} state_t;

    state_t        state, next_state;
    logic          if_pend, d_pend;
    logic [31:0]   if_addr_q, d_addr_q, d_wdata_q;
    logic          d_we_q;
    logic [3:0]    d_strb_q;
    logic [SW-1:0] starve_cnt;
    logic          abort, if_end, d_end, if_take, d_take, grant_if, grant_d;

    assign if_end   = (state == IF_XFER) && (BUS_READY || abort);
    assign d_end    = (state == D_XFER)  && (BUS_READY || abort);
    // Completion frees the slot on the same edge, so the owner may re-request then.
    assign if_take  = IF_REQ && (!if_pend || if_end);
    assign d_take   = D_REQ  && (!d_pend  || d_end);
    assign grant_if = (state == IDLE) && (next_state == IF_XFER);
    assign grant_d  = (state == IDLE) && (next_state == D_XFER);
    assign MEM_BUSY = d_pend;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (!NRST) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_pend && (!if_pend || starve_cnt != STARVE_LIM)) next_state = D_XFER;
                else if (if_pend)                                   next_state = IF_XFER;
            end
            IF_XFER, D_XFER: if (BUS_READY || abort) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        BUS_VALID = 1'b0;
        BUS_WE    = 1'b0;
        BUS_ADDR  = '0;
        BUS_WDATA = '0;
        BUS_STRB  = '0;
        case (state)
            IF_XFER: begin
                BUS_VALID = 1'b1;
                BUS_ADDR  = if_addr_q;
                BUS_STRB  = 4'hF;
            end
            D_XFER: begin
                BUS_VALID = 1'b1;
                BUS_WE    = d_we_q;
                BUS_ADDR  = d_addr_q;
                BUS_WDATA = d_wdata_q;
                BUS_STRB  = d_strb_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            if_pend <= 1'b0;
            d_pend  <= 1'b0;
        end else begin
            if (if_take)     if_pend <= 1'b1;
            else if (if_end) if_pend <= 1'b0;
            if (d_take)      d_pend  <= 1'b1;
            else if (d_end)  d_pend  <= 1'b0;
        end
    end

    // NOTE: request fields are only observed while their pending flag is set, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (if_take) if_addr_q <= IF_ADDR;
        if (d_take) begin
            d_we_q    <= D_WE;
            d_addr_q  <= D_ADDR;
            d_wdata_q <= D_WDATA;
            d_strb_q  <= D_STRB;
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST)                                            starve_cnt <= '0;
        else if (grant_if)                                    starve_cnt <= '0;
        else if (grant_d && if_pend && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            IF_DONE  <= 1'b0;
            D_DONE   <= 1'b0;
            IF_RDATA <= NOP_INSN;
            D_RDATA  <= '0;
        end else begin
            IF_DONE <= if_end;
            D_DONE  <= d_end;
            if (if_end)            IF_RDATA <= abort ? NOP_INSN : BUS_RDATA;
            if (d_end && !d_we_q)  D_RDATA  <= abort ? 32'h0 : BUS_RDATA;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;

    assign abort = (state != IDLE) && !BUS_READY && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (!NRST)                                   wd_cnt <= '0;
        else if (state != IDLE && !BUS_READY && !abort) wd_cnt <= wd_cnt + 1'b1;
        else                                         wd_cnt <= '0;
    end

    always_ff @(posedge CLK) begin
        if (!NRST) BUS_ERR <= 1'b0;
        else       BUS_ERR <= abort;
    end
`else
    // Keeps the watchdog parameter referenced when the watchdog is compiled out.
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign abort   = 1'b0;
    assign BUS_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: latency, priority, starvation limit, stalls, reset, timeout.
module tb_core_mem_arbiter;

    logic        CLK = 1'b0;
    logic        NRST;
    logic        IF_REQ, D_REQ, D_WE, BUS_READY;
    logic [31:0] IF_ADDR, D_ADDR, D_WDATA, BUS_RDATA;
    logic [3:0]  D_STRB;
    logic [31:0] IF_RDATA, D_RDATA, BUS_ADDR, BUS_WDATA;
    logic        IF_DONE, D_DONE, BUS_VALID, BUS_WE, MEM_BUSY, BUS_ERR;
    logic [3:0]  BUS_STRB;

    int vectors = 0;
    int miscompares = 0;

    core_mem_arbiter #(.STARVE_MAX(4), .TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .NRST(NRST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_DONE(IF_DONE),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_STRB(D_STRB),
        .D_RDATA(D_RDATA), .D_DONE(D_DONE),
        .BUS_VALID(BUS_VALID), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA),
        .BUS_STRB(BUS_STRB), .BUS_READY(BUS_READY), .BUS_RDATA(BUS_RDATA),
        .MEM_BUSY(MEM_BUSY), .BUS_ERR(BUS_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL bench_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        NRST = 1'b0; IF_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0; BUS_READY = 1'b1;
        IF_ADDR = '0; D_ADDR = '0; D_WDATA = '0; D_STRB = '0; BUS_RDATA = '0;
        step(); step();
        check("rst_valid", BUS_VALID, 0);
        check("rst_we",    BUS_WE,    0);
        check("rst_strb",  BUS_STRB,  0);
        check("rst_addr",  BUS_ADDR,  0);
        check("rst_wdata", BUS_WDATA, 0);
        check("rst_ifdone", IF_DONE,  0);
        check("rst_ddone", D_DONE,    0);
        check("rst_err",   BUS_ERR,   0);
        check("rst_irdata", IF_RDATA, 32'h13);
        check("rst_drdata", D_RDATA,  0);
        check("rst_busy",  MEM_BUSY,  0);
        NRST = 1'b1;
        step();

        // Minimum-latency fetch.
        IF_REQ = 1'b1; IF_ADDR = 32'h100; BUS_RDATA = 32'hDEAD_BEEF;
        step();
        IF_REQ = 1'b0;
        check("f_lat_k_valid", BUS_VALID, 0);
        step();
        check("f_valid", BUS_VALID, 1);
        check("f_addr",  BUS_ADDR,  32'h100);
        check("f_strb",  BUS_STRB,  4'hF);
        check("f_we",    BUS_WE,    0);
        step();
        check("f_done",  IF_DONE,   1);
        check("f_rdata", IF_RDATA,  32'hDEAD_BEEF);
        check("f_idle",  BUS_VALID, 0);
        step();
        check("f_done_pulse", IF_DONE, 0);

        // Simultaneous store and fetch: store wins.
        IF_REQ = 1'b1; IF_ADDR = 32'h200;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h2000; D_WDATA = 32'hA5A5_0001; D_STRB = 4'h3;
        step();
        IF_REQ = 1'b0; D_REQ = 1'b0;
        check("sim_busy_pend", MEM_BUSY, 1);
        step();
        BUS_RDATA = 32'h1111_2222;
        check("sim_d_addr",  BUS_ADDR,  32'h2000);
        check("sim_d_we",    BUS_WE,    1);
        check("sim_d_strb",  BUS_STRB,  4'h3);
        check("sim_d_wdata", BUS_WDATA, 32'hA5A5_0001);
        check("sim_busy_xfer", MEM_BUSY, 1);
        step();
        check("sim_d_done",  D_DONE,   1);
        check("sim_busy_off", MEM_BUSY, 0);
        check("sim_store_keeps_drdata", D_RDATA, 0);
        step();
        check("sim_f_addr",  BUS_ADDR, 32'h200);
        check("sim_f_strb",  BUS_STRB, 4'hF);
        check("sim_f_we",    BUS_WE,   0);
        step();
        check("sim_f_done",  IF_DONE,  1);
        check("sim_f_rdata", IF_RDATA, 32'h1111_2222);

        // Starvation limit: four data grants, then the fetch.
        IF_REQ = 1'b1; IF_ADDR = 32'h300;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h4000; D_STRB = 4'hF;
        step();
        IF_REQ = 1'b0; D_REQ = 1'b0;
        for (int g = 0; g < 4; g++) begin
            step();
            check($sformatf("stv_d%0d_addr", g), BUS_ADDR, 32'h4000 + 32'(g * 4));
            check($sformatf("stv_d%0d_we", g),   BUS_WE,   0);
            BUS_RDATA = 32'hC000_0000 + 32'(g);
            D_REQ = 1'b1; D_ADDR = 32'h4000 + 32'((g + 1) * 4);
            step();
            D_REQ = 1'b0;
            check($sformatf("stv_d%0d_done", g),  D_DONE,  1);
            check($sformatf("stv_d%0d_rdata", g), D_RDATA, 32'hC000_0000 + 32'(g));
        end
        step();
        check("stv_f_addr", BUS_ADDR, 32'h300);
        check("stv_f_strb", BUS_STRB, 4'hF);
        IF_REQ = 1'b1; IF_ADDR = 32'h304; BUS_RDATA = 32'h1234_5678;
        step();
        IF_REQ = 1'b0;
        check("stv_f_done",  IF_DONE,  1);
        check("stv_f_rdata", IF_RDATA, 32'h1234_5678);
        step();
        check("stv_cnt_cleared_d_wins", BUS_ADDR, 32'h4010);
        BUS_RDATA = 32'hC000_0004;
        step();
        check("stv_d4_done", D_DONE, 1);
        step();
        check("stv_f2_addr", BUS_ADDR, 32'h304);
        step();
        check("stv_f2_done", IF_DONE, 1);

        // Load stalled five cycles.
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h5000; D_STRB = 4'hC;
        step();
        D_REQ = 1'b0; BUS_READY = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_valid", i), BUS_VALID, 1);
            check($sformatf("stall%0d_addr", i),  BUS_ADDR,  32'h5000);
            check($sformatf("stall%0d_strb", i),  BUS_STRB,  4'hC);
            check($sformatf("stall%0d_we", i),    BUS_WE,    0);
            check($sformatf("stall%0d_done", i),  D_DONE,    0);
            step();
        end
        check("stall_still_valid", BUS_VALID, 1);
        BUS_READY = 1'b1; BUS_RDATA = 32'h5A5A_1234;
        step();
        check("stall_done",  D_DONE,  1);
        check("stall_rdata", D_RDATA, 32'h5A5A_1234);
        check("stall_err",   BUS_ERR, 0);
        step();
        check("stall_done_once", D_DONE, 0);

        // Reset during a data transfer with a fetch also pending.
        IF_REQ = 1'b1; IF_ADDR = 32'h600;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h6000; D_WDATA = 32'h0BAD_F00D; D_STRB = 4'hF;
        step();
        IF_REQ = 1'b0; D_REQ = 1'b0; BUS_READY = 1'b0;
        step();
        check("rx_d_addr", BUS_ADDR, 32'h6000);
        NRST = 1'b0;
        step();
        check("rx_valid", BUS_VALID, 0);
        check("rx_busy",  MEM_BUSY,  0);
        check("rx_ddone", D_DONE,    0);
        check("rx_drdata", D_RDATA,  0);
        NRST = 1'b1; BUS_READY = 1'b1;
        step();
        check("rx_flags_clear", BUS_VALID, 0);
        check("rx_no_ddone",    D_DONE,    0);
        check("rx_no_ifdone",   IF_DONE,   0);
        step();
        check("rx_still_idle",  BUS_VALID, 0);
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h6100;
        step();
        D_REQ = 1'b0;
        step();
        check("rx_new_addr", BUS_ADDR, 32'h6100);
        BUS_RDATA = 32'h7777_8888;
        step();
        check("rx_new_done",  D_DONE,  1);
        check("rx_new_rdata", D_RDATA, 32'h7777_8888);
        IF_REQ = 1'b1; IF_ADDR = 32'h180; BUS_RDATA = 32'hABCD_0000;
        step();
        IF_REQ = 1'b0;
        step();
        step();
        check("rx_fetch_rdata", IF_RDATA, 32'hABCD_0000);

        // Fetch with BUS_READY stuck low.
        IF_REQ = 1'b1; IF_ADDR = 32'h700; BUS_READY = 1'b0;
        step();
        IF_REQ = 1'b0;
        step();
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            check($sformatf("to%0d_valid", i), BUS_VALID, 1);
            check($sformatf("to%0d_done", i),  IF_DONE,   0);
            check($sformatf("to%0d_err", i),   BUS_ERR,   0);
            step();
        end
        check("to_done",  IF_DONE,   1);
        check("to_err",   BUS_ERR,   1);
        check("to_rdata", IF_RDATA,  32'h13);
        check("to_valid", BUS_VALID, 0);
        step();
        check("to_done_pulse", IF_DONE, 0);
        check("to_err_pulse",  BUS_ERR, 0);
        BUS_READY = 1'b1;
`else
        for (int i = 0; i < 12; i++) begin
            check($sformatf("wait%0d_valid", i), BUS_VALID, 1);
            check($sformatf("wait%0d_done", i),  IF_DONE,   0);
            check($sformatf("wait%0d_err", i),   BUS_ERR,   0);
            step();
        end
        BUS_READY = 1'b1; BUS_RDATA = 32'h0000_0700;
        step();
        check("wait_done",  IF_DONE,  1);
        check("wait_rdata", IF_RDATA, 32'h0000_0700);
        check("wait_err",   BUS_ERR,  0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
